// File: rtl/redmule_tile_ctrl.sv
// RedMulE tile controller: sequences one GEMM job (first load, W-row streaming,
// optional Y preload, Z buffering and Z stores) and counts busy cycles.
module redmule_tile_ctrl #(
  parameter int unsigned Height      = 4,
  parameter int unsigned Width       = 8,
  parameter int unsigned NumPipeRegs = 3,
  parameter int unsigned CntWidth    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic                acc_mode_i,
  input  logic [CntWidth-1:0] w_iters_i,
  input  logic [CntWidth-1:0] tot_stores_i,
  input  logic                w_loaded_i,
  input  logic                y_loaded_i,
  input  logic                reg_enable_i,
  input  logic                zbuf_full_i,
  input  logic                zbuf_empty_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                cfg_err_o,
  output logic                first_load_o,
  output logic                y_preload_o,
  output logic                storing_o,
  output logic                finished_o,
  output logic                sched_rst_o,
  output logic                flush_o,
  output logic                accumulate_o,
  output logic                w_shift_o,
  output logic                z_fill_o,
  output logic                z_buffer_clk_en_o,
  output logic [31:0]         cycles_o
);

  localparam int unsigned Tile      = (NumPipeRegs + 1) * Height;
  localparam int unsigned CompWidth = $clog2(Height) + 1;

  // An illegal geometry turns every start into a configuration error.
  localparam bit GeomOk = (Height >= 2) && (Height <= 32) && (Width >= 1) && (Tile >= Height);

  localparam logic [CompWidth-1:0] CompWrap  = CompWidth'(Height - 1);
  localparam logic [CompWidth-1:0] CompDrain = CompWidth'(Height - 2);

  typedef enum logic [2:0] {
    StIdle, StStarting, StPreload, StComputing, StBuffering, StStoring, StFinished
  } state_e;

  state_e                state_q;
  logic [CntWidth-1:0]   row_cnt_q;
  logic [CompWidth-1:0]  comp_cnt_q;
  logic [CntWidth-1:0]   store_cnt_q;
  logic [CntWidth-1:0]   w_iters_q;
  logic [CntWidth-1:0]   tot_stores_q;
  logic                  acc_mode_q;
  logic                  acc_q;
  logic                  last_row_q;
  logic                  cfg_err_q;
  logic [31:0]           cycles_q;
  logic                  comp_en;
  logic                  last_store;

  // Compute counter only runs once enough W rows are in flight to fill the array.
  assign comp_en    = (row_cnt_q >= CntWidth'(Height)) || (row_cnt_q >= w_iters_q);
  assign last_store = (store_cnt_q == tot_stores_q - 1'b1);

  // Job sequencing, row/compute/store counters and sticky config error.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q      <= StIdle;
      row_cnt_q    <= '0;
      comp_cnt_q   <= '0;
      store_cnt_q  <= '0;
      w_iters_q    <= '0;
      tot_stores_q <= '0;
      acc_mode_q   <= 1'b0;
      acc_q        <= 1'b0;
      last_row_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      // Loads are counted in any active state; later assignments below override.
      if (w_loaded_i && (state_q != StIdle) && (state_q != StFinished)) begin
        row_cnt_q <= row_cnt_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            w_iters_q    <= w_iters_i;
            tot_stores_q <= tot_stores_i;
            acc_mode_q   <= acc_mode_i;
            if ((w_iters_i == '0) || (tot_stores_i == '0) || !GeomOk) begin
              cfg_err_q <= 1'b1;
              state_q   <= StFinished;
            end else begin
              cfg_err_q <= 1'b0;
              state_q   <= StStarting;
            end
          end
        end
        StStarting: begin
          if (w_loaded_i) state_q <= acc_mode_q ? StPreload : StComputing;
        end
        StPreload: begin
          if (y_loaded_i) begin
            acc_q   <= 1'b1;
            state_q <= StComputing;
          end
        end
        StComputing: begin
          if (row_cnt_q == w_iters_q) last_row_q <= 1'b1;
          if (last_row_q && (comp_cnt_q == CompDrain) && reg_enable_i) begin
            // The load seen on this cycle is the first row of the next pass.
            row_cnt_q  <= CntWidth'(1);
            comp_cnt_q <= '0;
            acc_q      <= 1'b0;
            state_q    <= StBuffering;
          end else if (!last_row_q && (comp_cnt_q == CompWrap)) begin
            acc_q      <= 1'b1;
            comp_cnt_q <= '0;
          end else if (comp_en && reg_enable_i) begin
            comp_cnt_q <= comp_cnt_q + 1'b1;
          end
        end
        StBuffering: begin
          last_row_q <= 1'b0;
          if (zbuf_full_i) begin
            acc_q   <= 1'b1;
            state_q <= StStoring;
          end
        end
        StStoring: begin
          if (zbuf_empty_i) begin
            if (last_store) begin
              state_q <= StFinished;
            end else begin
              store_cnt_q <= store_cnt_q + 1'b1;
              state_q     <= acc_mode_q ? StPreload : StComputing;
            end
          end
        end
        StFinished: begin
          row_cnt_q   <= '0;
          comp_cnt_q  <= '0;
          store_cnt_q <= '0;
          acc_q       <= 1'b0;
          last_row_q  <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Busy-cycle counter: restarts on an accepted start, saturates, holds when idle.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cycles_q <= '0;
    end else if ((state_q == StIdle) && start_i) begin
      cycles_q <= '0;
    end else if (busy_o && (cycles_q != '1)) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  // Output decode from the current state.
  always_comb begin
    busy_o            = (state_q != StIdle) && (state_q != StFinished);
    w_shift_o         = !((state_q == StIdle) || (state_q == StStarting) ||
                          (state_q == StPreload));
    done_o            = 1'b0;
    first_load_o      = 1'b0;
    y_preload_o       = 1'b0;
    storing_o         = 1'b0;
    finished_o        = 1'b0;
    sched_rst_o       = 1'b0;
    flush_o           = 1'b0;
    z_fill_o          = 1'b0;
    // Keep the Z buffer clocked while a clear flushes it.
    z_buffer_clk_en_o = clear_i;
    unique case (state_q)
      StStarting:  first_load_o = 1'b1;
      StPreload:   y_preload_o  = 1'b1;
      StBuffering: begin
        z_buffer_clk_en_o = 1'b1;
        z_fill_o          = reg_enable_i;
      end
      StStoring: begin
        storing_o  = 1'b1;
        finished_o = zbuf_empty_i && last_store;
      end
      StFinished: begin
        done_o      = 1'b1;
        flush_o     = 1'b1;
        sched_rst_o = 1'b1;
        finished_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign accumulate_o = acc_q;
  assign cfg_err_o    = cfg_err_q;
  assign cycles_o     = cycles_q;

endmodule
